// File: rtl/chip8_pkg.sv
// Shared types and defaults for the memory arbiter.
package chip8_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  // Who owns the memory bus.
  typedef enum logic [1:0] {
    REQ_FETCH  = 2'd0,
    REQ_DATA   = 2'd1,
    REQ_SPRITE = 2'd2
  } req_id_t;

  // Arbiter sequencing: IDLE -> ACCESS (bus strobe) -> RESP (read data back).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: fetch first, data/sprite round-robin,
// and the round-robin winner overrides fetch once the starvation limit is hit.
module mem_arb_pick
  import chip8_pkg::*;
(
  input  logic       f_req,
  input  logic       d_req,
  input  logic       s_req,
  input  logic       sprite_turn,
  input  logic       starved,
  output logic       any,
  output logic [1:0] winner
);

  logic    rr_req;
  req_id_t rr_pick;

  // Resolve the data/sprite tie first, then weigh it against fetch.
  always_comb begin
    any     = f_req | d_req | s_req;
    rr_req  = d_req | s_req;
    rr_pick = (d_req && !(s_req && sprite_turn)) ? REQ_DATA : REQ_SPRITE;
    if (f_req && !(starved && rr_req)) begin
      winner = REQ_FETCH;
    end else if (rr_req) begin
      winner = rr_pick;
    end else begin
      winner = REQ_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way single-port memory arbiter (fetch, data, sprite).
// One access per two cycles: ACCESS drives the bus, RESP returns read data
// and re-arbitrates so back-to-back requests lose no cycle.
module mem_arbiter
  import chip8_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              s_req,
  input  logic [ADDR_W-1:0] s_addr,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state_reg;
  req_id_t           owner_reg;
  logic [CNT_W-1:0]  starve_reg;
  logic              sprite_turn_reg;  // 0: data wins the next tie

  logic              pick_any;
  logic [1:0]        pick_raw;
  req_id_t           pick_id;
  logic              starved;
  logic [ADDR_W-1:0] pick_addr;

  assign starved = (starve_reg == CNT_W'(STARVE_MAX));
  assign pick_id = req_id_t'(pick_raw);
  assign rdata   = mem_rdata;

  mem_arb_pick u_pick (
    .f_req       (f_req),
    .d_req       (d_req),
    .s_req       (s_req),
    .sprite_turn (sprite_turn_reg),
    .starved     (starved),
    .any         (pick_any),
    .winner      (pick_raw)
  );

  // Address of whichever requester the picker selected.
  always_comb begin
    case (pick_id)
      REQ_DATA:   pick_addr = d_addr;
      REQ_SPRITE: pick_addr = s_addr;
      default:    pick_addr = f_addr;
    endcase
  end

  // Arbiter FSM; every bus and handshake output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      owner_reg       <= REQ_FETCH;
      starve_reg      <= '0;
      sprite_turn_reg <= 1'b0;
      f_gnt           <= 1'b0;
      d_gnt           <= 1'b0;
      s_gnt           <= 1'b0;
      f_rvalid        <= 1'b0;
      d_rvalid        <= 1'b0;
      s_rvalid        <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      // Strobes are single-cycle pulses; address and write data hold.
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      s_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      s_rvalid <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      case (state_reg)
        IDLE, RESP: begin
          if (pick_any) begin
            state_reg <= ACCESS;
            owner_reg <= pick_id;
            mem_en    <= 1'b1;
            mem_addr  <= pick_addr;
            mem_wdata <= d_wdata;
            case (pick_id)
              REQ_DATA: begin
                d_gnt           <= 1'b1;
                mem_we          <= d_we;
                starve_reg      <= '0;
                sprite_turn_reg <= 1'b1;
              end
              REQ_SPRITE: begin
                s_gnt           <= 1'b1;
                starve_reg      <= '0;
                sprite_turn_reg <= 1'b0;
              end
              default: begin
                f_gnt <= 1'b1;
                if ((d_req || s_req) && !starved) begin
                  starve_reg <= starve_reg + 1'b1;
                end
              end
            endcase
          end else begin
            state_reg <= IDLE;
          end
        end
        ACCESS: begin
          // mem_we is still high here exactly when this access was a write.
          state_reg <= RESP;
          f_rvalid  <= (owner_reg == REQ_FETCH);
          d_rvalid  <= (owner_reg == REQ_DATA) && !mem_we;
          s_rvalid  <= (owner_reg == REQ_SPRITE);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts
// grants and read data; a monitor on the falling edge checks the DUT.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a [3];
  logic [AW-1:0] addr_a [3];
  logic          d_we_v;
  logic [DW-1:0] d_wdata_v;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, s_gnt, s_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(req_a[0]), .f_addr(addr_a[0]), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(req_a[1]), .d_we(d_we_v), .d_addr(addr_a[1]), .d_wdata(d_wdata_v),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .s_req(req_a[2]), .s_addr(addr_a[2]), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  // Behavioural memory on the DUT bus, and the model's own copy.
  logic [DW-1:0] ram [4096];
  logic [DW-1:0] model_mem [4096];

  // Reference model state.
  int starve = 0;
  bit data_turn = 1'b1;
  bit prev_gnt = 1'b0;
  int last_win = -1;

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a * 40503 + 7);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = init_word(i);
      model_mem[i] = init_word(i);
    end
    ram[12'h200] = 16'h6A05;
    model_mem[12'h200] = 16'h6A05;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: advance to just after the edge and let the model decide
  // what the arbiter did with the requests present at that edge.
  task automatic step();
    exp_t e;
    int   w;
    bit   rr_ok;
    @(posedge clk);
    #1;
    cyc++;
    last_win = -1;
    if (!rst_n) begin
      starve = 0;
      data_turn = 1'b1;
      prev_gnt = 1'b0;
    end else if (prev_gnt) begin
      prev_gnt = 1'b0;  // the bus is busy for the access just granted
    end else if (req_a[0] || req_a[1] || req_a[2]) begin
      rr_ok = req_a[1] || req_a[2];
      w = (req_a[1] && (!req_a[2] || data_turn)) ? 1 : 2;
      if (req_a[0] && !(rr_ok && starve >= SMAX)) w = 0;
      if (w == 0) begin
        if (rr_ok && starve < SMAX) starve++;
      end else begin
        starve = 0;
        data_turn = (w == 2);
      end
      e.id = w;
      e.cyc = cyc;
      e.addr = addr_a[w];
      e.we = (w == 1) && d_we_v;
      e.data = d_wdata_v;
      gq.push_back(e);
      if (e.we) begin
        model_mem[e.addr] = d_wdata_v;
      end else begin
        e.cyc = cyc + 1;
        e.data = model_mem[e.addr];
        rq.push_back(e);
      end
      prev_gnt = 1'b1;
      last_win = w;
    end
  endtask

  task automatic tick_drop();
    step();
    if (last_win >= 0) req_a[last_win] = 1'b0;
  endtask

  // Monitor: compare DUT outputs with queued expectations mid-cycle.
  int            gid, rid, gcnt, rcnt;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  exp_t          m;

  always @(negedge clk) begin
    if (!rst_n) begin
      check({f_gnt, d_gnt, s_gnt, f_rvalid, d_rvalid, s_rvalid, mem_en, mem_we} == 8'h00,
            "reset_strobes", {f_gnt, d_gnt, s_gnt, f_rvalid, d_rvalid, s_rvalid, mem_en, mem_we}, 0);
      check(mem_addr == '0 && mem_wdata == '0, "reset_bus", {mem_addr, mem_wdata}, 0);
      last_addr = '0;
      last_wdata = '0;
    end else begin
      gcnt = int'(f_gnt) + int'(d_gnt) + int'(s_gnt);
      rcnt = int'(f_rvalid) + int'(d_rvalid) + int'(s_rvalid);
      check(gcnt <= 1 && rcnt <= 1, "one_hot", {gcnt[15:0], rcnt[15:0]}, 32'h0001_0001);
      check(!((f_gnt && f_rvalid) || (d_gnt && d_rvalid) || (s_gnt && s_rvalid)),
            "gnt_rvalid_overlap", {f_gnt, f_rvalid, d_gnt, d_rvalid, s_gnt, s_rvalid}, 0);
      if (gcnt != 0) begin
        gid = f_gnt ? 0 : (d_gnt ? 1 : 2);
        if (gq.size() == 0) begin
          check(1'b0, "unexpected_gnt", gid, 32'hFFFF_FFFF);
        end else begin
          m = gq.pop_front();
          $display("txn cycle %0d gnt id=%0d addr=0x%0h we=%0d wdata=0x%0h", cyc, gid, mem_addr, mem_we, mem_wdata);
          check(gid == m.id, "gnt_id", gid, m.id);
          check(cyc == m.cyc, "gnt_cycle", cyc, m.cyc);
          check(mem_en == 1'b1, "gnt_mem_en", mem_en, 1);
          check(mem_addr == m.addr, "gnt_addr", mem_addr, m.addr);
          check(mem_we == m.we, "gnt_we", mem_we, m.we);
          check(mem_wdata == m.data, "gnt_wdata", mem_wdata, m.data);
          last_addr = m.addr;
          last_wdata = m.data;
        end
      end else begin
        check(!mem_en && !mem_we, "idle_strobes", {mem_en, mem_we}, 0);
        check(mem_addr == last_addr && mem_wdata == last_wdata, "idle_hold",
              {mem_addr, mem_wdata}, {last_addr, last_wdata});
      end
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        m = gq.pop_front();
        check(1'b0, "missing_gnt", m.id, m.cyc);
      end
      if (rcnt != 0) begin
        rid = f_rvalid ? 0 : (d_rvalid ? 1 : 2);
        if (rq.size() == 0) begin
          check(1'b0, "unexpected_rvalid", rid, 32'hFFFF_FFFF);
        end else begin
          m = rq.pop_front();
          $display("txn cycle %0d rvalid id=%0d rdata=0x%0h", cyc, rid, rdata);
          check(rid == m.id, "rvalid_id", rid, m.id);
          check(cyc == m.cyc, "rvalid_cycle", cyc, m.cyc);
          check(rdata == m.data, "rdata", rdata, m.data);
        end
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        m = rq.pop_front();
        check(1'b0, "missing_rvalid", m.id, m.cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_a[i] = 1'b0;
      addr_a[i] = '0;
    end
    d_we_v = 1'b0;
    d_wdata_v = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Lone fetch from 0x200.
    req_a[0] = 1'b1; addr_a[0] = 12'h200;
    tick_drop();
    repeat (3) step();

    // Data write of 0xBEEF to 0x300, then read it back.
    req_a[1] = 1'b1; d_we_v = 1'b1; addr_a[1] = 12'h300; d_wdata_v = 16'hBEEF;
    tick_drop();
    repeat (2) step();
    req_a[1] = 1'b1; d_we_v = 1'b0;
    tick_drop();
    repeat (3) step();

    // Data and sprite both held: alternate service.
    req_a[1] = 1'b1; addr_a[1] = 12'h201;
    req_a[2] = 1'b1; addr_a[2] = 12'h202;
    repeat (9) step();
    req_a[1] = 1'b0; req_a[2] = 1'b0;
    repeat (3) step();

    // Fetch and data held: data breaks through after STARVE_MAX fetches.
    req_a[0] = 1'b1; addr_a[0] = 12'h204;
    req_a[1] = 1'b1; addr_a[1] = 12'h205;
    repeat (24) step();
    req_a[0] = 1'b0; req_a[1] = 1'b0;
    repeat (3) step();

    // All three at once from IDLE.
    req_a[0] = 1'b1; req_a[1] = 1'b1; req_a[2] = 1'b1;
    repeat (8) tick_drop();
    repeat (2) step();

    // Reset in the RESP cycle of a sprite read, with data and sprite pending.
    req_a[2] = 1'b1; addr_a[2] = 12'h206;
    for (int i = 0; i < 5 && last_win != 2; i++) step();
    check(last_win == 2, "sprite_setup", last_win, 2);
    req_a[1] = 1'b1; addr_a[1] = 12'h207; d_we_v = 1'b0;
    addr_a[2] = 12'h208;
    step();
    rst_n = 1'b0;
    gq.delete();
    rq.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) tick_drop();
    repeat (2) step();

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (last_win == i) begin
          req_a[i] = 1'($urandom_range(1, 0));
          if (req_a[i]) addr_a[i] = 12'h200 + 12'($urandom_range(15, 0));
          if (req_a[i] && i == 1) begin
            d_we_v = 1'($urandom_range(1, 0));
            d_wdata_v = 16'($urandom);
          end
        end else if (!req_a[i] && $urandom_range(99, 0) < 45) begin
          req_a[i] = 1'b1;
          addr_a[i] = 12'h200 + 12'($urandom_range(15, 0));
          if (i == 1) begin
            d_we_v = 1'($urandom_range(1, 0));
            d_wdata_v = 16'($urandom);
          end
        end
      end
      step();
    end
    for (int i = 0; i < 3; i++) req_a[i] = 1'b0;
    repeat (5) step();
    @(negedge clk);
    #1;
    check(gq.size() == 0, "gnt_queue_drained", gq.size(), 0);
    check(rq.size() == 0, "rvalid_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
